unpool_stream: RTL and testbench

//  Streaming 2x2 max-unpooling stage for the decoder path. Accepts a pooled
//  map (value + 2-bit argmax history) in raster order over a valid/ready link.

---
 rtl/unpool_pkg.sv | 34 +++
 rtl/unpool_stream_if.sv | 35 +++
 rtl/unpool_row_bank.sv | 41 ++++
 rtl/unpool_stream.sv | 252 +++++++++++++++++++++++++
 tb/tb_unpool_stream.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unpool_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : unpool_pkg                                                    |
// | Purpose  : Shared constants for the 2x2 max-unpooling stream stage:      |
// |            argmax position codes, mode codes, FSM state encodings and a  |
// |            ceil(log2) helper used to size counters.                      |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package unpool_pkg;

   // Argmax position inside a 2x2 output window, {row, col} of the window.
   localparam logic [1:0] IDX_TL = 2'd0;
   localparam logic [1:0] IDX_TR = 2'd1;
   localparam logic [1:0] IDX_BL = 2'd2;
   localparam logic [1:0] IDX_BR = 2'd3;

   localparam logic MODE_MAX = 1'b0;   // value only at argmax position
   localparam logic MODE_REP = 1'b1;   // value replicated to all four

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // ceil(log2(value)); clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/unpool_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : unpool_stream_if                                              |
// | Purpose  : Pooled-input and unpooled-output valid/ready links of the     |
// |            unpooling stage.                                              |
// | Ports    : in_valid/in_ready/in_value/in_index  pooled pixel stream      |
// |            out_valid/out_ready/out_value/out_ch/out_frame_end  output    |
// |            master = stream source/sink side, slave = unpool_stream       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface unpool_stream_if #(
   parameter int DATA_W = 16,
   parameter int CHW    = 1
) ();
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_value;
   logic [1:0]        in_index;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_value;
   logic [CHW-1:0]    out_ch;
   logic              out_frame_end;

   modport master (
      output in_valid, in_value, in_index, out_ready,
      input  in_ready, out_valid, out_value, out_ch, out_frame_end
   );

   modport slave (
      input  in_valid, in_value, in_index, out_ready,
      output in_ready, out_valid, out_value, out_ch, out_frame_end
   );
endinterface
`default_nettype wire

// File: rtl/unpool_row_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : unpool_row_bank                                               |
// | Purpose  : Two ping-pong row banks of MAP_W {index,value} entries.       |
// |            One synchronous write port, one combinational read port.      |
// | Ports    : clk                         clock                             |
// |            i_we/i_wbank/i_wcol         write enable, bank, column        |
// |            i_wvalue/i_windex           write data                        |
// |            i_rbank/i_rk                read bank, entry                  |
// |            o_rvalue/o_rindex           read data                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module unpool_row_bank #(
   parameter int DATA_W = 16,
   parameter int MAP_W  = 8,
   parameter int KW     = 3
) (
   input  wire logic              clk,
   input  wire logic              i_we,
   input  wire logic              i_wbank,
   input  wire logic [KW-1:0]     i_wcol,
   input  wire logic [DATA_W-1:0] i_wvalue,
   input  wire logic [1:0]        i_windex,
   input  wire logic              i_rbank,
   input  wire logic [KW-1:0]     i_rk,
   output logic      [DATA_W-1:0] o_rvalue,
   output logic      [1:0]        o_rindex
);

   // Storage needs no reset: a bank is only read after its full flag is set,
   // and that flag is set only once every entry of the row has been written.
   logic [DATA_W+1:0] r_mem [2][MAP_W];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_wbank][i_wcol] <= {i_windex, i_wvalue};
   end

   assign {o_rindex, o_rvalue} = r_mem[i_rbank][i_rk];

endmodule
`default_nettype wire

// File: rtl/unpool_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : unpool_stream                                                 |
// | Purpose  : Streaming 2x2 max-unpooling. Buffers pooled rows in two       |
// |            ping-pong banks and emits each row as two 2x-wide output rows;|
// |            mode 0 places the value at its argmax position, mode 1        |
// |            replicates it. CH channels are processed per start.           |
// | Ports    : clk      clock, rising edge                                   |
// |            reset_n  asynchronous active-low reset                        |
// |            start    begin CH frames (ignored while busy)                 |
// |            mode     0 max-unpool / 1 replicate, latched on start         |
// |            busy     high from accepted start until done                  |
// |            done     one-cycle pulse after the last output handshake      |
// |            bus      stream interface (slave modport)                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module unpool_stream
   import unpool_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int MAP_W  = 8,    // >= 2
   parameter int MAP_H  = 8,
   parameter int CH     = 1
) (
   input  wire logic  clk,
   input  wire logic  reset_n,
   input  wire logic  start,
   input  wire logic  mode,
   output logic       busy,
   output logic       done,
   unpool_stream_if.slave bus
);

   localparam int KW    = clog2(MAP_W);
   localparam int OCW   = KW + 1;
   localparam int ORW   = (MAP_H > 0) ? clog2(2 * MAP_H) : 1;
   localparam int CHW   = clog2(CH) + 1;
   localparam int TOTAL = MAP_W * MAP_H * CH;
   localparam int LW    = clog2(TOTAL + 1);

   localparam logic [KW-1:0]  c_wcol_last = KW'(MAP_W - 1);
   localparam logic [OCW-1:0] c_ocol_last = OCW'(2 * MAP_W - 1);
   localparam logic [ORW-1:0] c_orow_last = ORW'(2 * MAP_H - 1);
   localparam logic [CHW-1:0] c_ch_last   = CHW'(CH - 1);

   logic [1:0]        r_state;
   logic              r_mode;
   // write side
   logic              r_wbank;
   logic [KW-1:0]     r_wcol;
   logic [LW-1:0]     r_in_left;
   // bank flags
   logic [1:0]        r_bank_full;
   logic [1:0]        r_full_d;
   // read side
   logic              r_rbank;
   logic              r_sub;
   logic [OCW-1:0]    r_ocol;
   logic [ORW-1:0]    r_orow;
   // output register
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_value;
   logic [CHW-1:0]    r_out_ch;
   logic              r_out_frame_end;

   logic              w_run;
   logic              w_start_acc;
   logic              w_in_ready;
   logic              w_in_fire;
   logic              w_row_wr_done;
   logic              w_load;
   logic              w_rd_avail;
   logic              w_rd_fire;
   logic              w_ocol_last;
   logic              w_release;
   logic              w_frame_last;
   logic              w_out_fire;
   logic              w_last_hs;
   logic [1:0]        w_set_mask;
   logic [1:0]        w_clr_mask;
   logic [KW-1:0]     w_k;
   logic [1:0]        w_pos;
   logic [DATA_W-1:0] w_rvalue;
   logic [1:0]        w_rindex;
   logic [DATA_W-1:0] w_pix;

   assign w_run         = (r_state == ST_RUN);
   assign w_start_acc   = start & (r_state == ST_IDLE);
   assign w_in_ready    = w_run & ~r_bank_full[r_wbank] & (r_in_left != '0);
   assign w_in_fire     = bus.in_valid & w_in_ready;
   assign w_row_wr_done = w_in_fire & (r_wcol == c_wcol_last);

   // A newly filled bank becomes readable one cycle after its full flag is
   // set (r_full_d), giving the two-edge first-output latency.
   assign w_load       = ~r_out_valid | bus.out_ready;
   assign w_rd_avail   = w_run & r_bank_full[r_rbank] & r_full_d[r_rbank];
   assign w_rd_fire    = w_load & w_rd_avail;
   assign w_ocol_last  = (r_ocol == c_ocol_last);
   assign w_release    = w_rd_fire & r_sub & w_ocol_last;
   assign w_frame_last = (r_orow == c_orow_last) & w_ocol_last;
   assign w_out_fire   = r_out_valid & bus.out_ready;
   assign w_last_hs    = w_out_fire & r_out_frame_end & (r_out_ch == c_ch_last);

   assign w_set_mask = w_row_wr_done ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
   assign w_clr_mask = w_release     ? (r_rbank ? 2'b10 : 2'b01) : 2'b00;

   // Entry k covers output columns 2k and 2k+1; sub selects upper/lower row.
   assign w_k = r_ocol[OCW-1:1];

   always_comb begin
      w_pos = IDX_TL;
      case ({r_sub, r_ocol[0]})
         2'b00:   w_pos = IDX_TL;
         2'b01:   w_pos = IDX_TR;
         2'b10:   w_pos = IDX_BL;
         default: w_pos = IDX_BR;
      endcase
   end

   assign w_pix = ((r_mode == MODE_REP) || (w_pos == w_rindex)) ? w_rvalue : '0;

   unpool_row_bank #(
      .DATA_W (DATA_W),
      .MAP_W  (MAP_W),
      .KW     (KW)
   ) u_bank (
      .clk      (clk),
      .i_we     (w_in_fire),
      .i_wbank  (r_wbank),
      .i_wcol   (r_wcol),
      .i_wvalue (bus.in_value),
      .i_windex (bus.in_index),
      .i_rbank  (r_rbank),
      .i_rk     (w_k),
      .o_rvalue (w_rvalue),
      .o_rindex (w_rindex)
   );

   // FSM and mode latch
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_MAX;
      end else begin
         if (w_start_acc) r_mode <= mode;
         case (r_state)
            ST_IDLE: if (start)     r_state <= ST_RUN;
            ST_RUN:  if (w_last_hs) r_state <= ST_DONE;
            ST_DONE:                r_state <= ST_IDLE;
            default:                r_state <= ST_IDLE;
         endcase
      end
   end

   // Write side: input counter spans all channels, so writing may run a row
   // ahead into the next channel while the previous one drains.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wbank   <= 1'b0;
         r_wcol    <= '0;
         r_in_left <= '0;
      end else if (w_start_acc) begin
         r_wbank   <= 1'b0;
         r_wcol    <= '0;
         r_in_left <= LW'(TOTAL);
      end else if (w_in_fire) begin
         r_in_left <= r_in_left - LW'(1);
         if (w_row_wr_done) begin
            r_wcol  <= '0;
            r_wbank <= ~r_wbank;
         end else begin
            r_wcol  <= r_wcol + KW'(1);
         end
      end
   end

   // Set and release always target different banks, so both apply together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bank_full <= 2'b00;
         r_full_d    <= 2'b00;
      end else if (w_start_acc) begin
         r_bank_full <= 2'b00;
         r_full_d    <= 2'b00;
      end else begin
         r_bank_full <= (r_bank_full | w_set_mask) & ~w_clr_mask;
         r_full_d    <= r_bank_full & ~w_clr_mask;
      end
   end

   // Read side
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rbank <= 1'b0;
         r_sub   <= 1'b0;
         r_ocol  <= '0;
         r_orow  <= '0;
      end else if (w_start_acc) begin
         r_rbank <= 1'b0;
         r_sub   <= 1'b0;
         r_ocol  <= '0;
         r_orow  <= '0;
      end else if (w_rd_fire) begin
         if (w_ocol_last) begin
            r_ocol <= '0;
            r_sub  <= ~r_sub;
            if (r_sub) r_rbank <= ~r_rbank;
            r_orow <= (r_orow == c_orow_last) ? '0 : r_orow + ORW'(1);
         end else begin
            r_ocol <= r_ocol + OCW'(1);
         end
      end
   end

   // Output register: reloads whenever empty or being consumed; held otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid     <= 1'b0;
         r_out_value     <= '0;
         r_out_frame_end <= 1'b0;
      end else if (w_rd_fire) begin
         r_out_valid     <= 1'b1;
         r_out_value     <= w_pix;
         r_out_frame_end <= w_frame_last;
      end else if (w_load) begin
         r_out_valid     <= 1'b0;
         r_out_frame_end <= 1'b0;
      end
   end

   // The channel tag advances on the frame-end handshake, i.e. the same edge
   // that may load the first pixel of the next channel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_ch <= '0;
      end else if (w_start_acc) begin
         r_out_ch <= '0;
      end else if (w_out_fire & r_out_frame_end) begin
         r_out_ch <= (r_out_ch == c_ch_last) ? '0 : r_out_ch + CHW'(1);
      end
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.out_valid     = r_out_valid;
   assign bus.out_value     = r_out_value;
   assign bus.out_ch        = r_out_ch;
   assign bus.out_frame_end = r_out_frame_end;
   assign busy              = (r_state != ST_IDLE);
   assign done              = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_unpool_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_unpool_stream                                              |
// | Purpose  : Self-checking bench for unpool_stream (4x2 map, 2 channels):  |
// |            random stimulus, queue-based scoreboard fed by a reference    |
// |            model computed per output pixel from its window coordinates.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_unpool_stream;
   import unpool_pkg::*;

   localparam int DATA_W    = 16;
   localparam int MAP_W     = 4;
   localparam int MAP_H     = 2;
   localparam int CH        = 2;
   localparam int CHW       = clog2(CH) + 1;
   localparam int TOTAL_IN  = MAP_W * MAP_H * CH;
   localparam int TOTAL_OUT = 4 * TOTAL_IN;
   localparam int TMO       = 5000;

   typedef struct {
      logic [DATA_W-1:0] v;
      int                ch;
      bit                fe;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic start   = 1'b0;
   logic mode    = 1'b0;
   logic busy;
   logic done;

   unpool_stream_if #(.DATA_W(DATA_W), .CHW(CHW)) bus ();

   unpool_stream #(
      .DATA_W (DATA_W),
      .MAP_W  (MAP_W),
      .MAP_H  (MAP_H),
      .CH     (CH)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .mode    (mode),
      .busy    (busy),
      .done    (done),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   bit   mon_en = 1'b0;
   bit   abort = 1'b0;
   bit   force_stall = 1'b0;
   int   ready_pct = 100;
   int   job_outs = 0;
   int   in_acc = 0;
   int   first_valid_cyc = -1;
   int   row0_cyc = -1;
   int   last_hs_cyc = 0;
   bit   stall_prev = 1'b0;
   logic [DATA_W-1:0] stall_val = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, want, want);
      end
   endtask

   // Downstream ready, changed just after each rising edge.
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = !force_stall && ($urandom_range(99) < ready_pct);
      end
   end

   // Monitor: compares every output handshake against the scoreboard queue
   // and checks that a stalled output holds its value.
   always @(negedge clk) begin
      if (mon_en) begin
         if (stall_prev) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_value", 32'(bus.out_value), 32'(stall_val));
         end
         if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_output: got value 0x%0h, expected no output", bus.out_value);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_value", 32'(bus.out_value), 32'(e.v));
               chk("out_ch", 32'(bus.out_ch), 32'(e.ch));
               chk("out_frame_end", 32'(bus.out_frame_end), 32'(e.fe));
            end
            job_outs++;
            last_hs_cyc = cyc;
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         stall_val  = bus.out_value;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // pat: 0 random, 1 fixed first row {10,20,30,40}/{0,1,2,3}, 2 all -5 idx 3.
   task automatic run_job(input bit md, input int pat, input int in_pct, input int rdy,
                          input bit flip, input int stall_at, input int abort_at);
      logic [DATA_W-1:0] vals[TOTAL_IN];
      logic [1:0]        idxs[TOTAL_IN];
      for (int i = 0; i < TOTAL_IN; i++) begin
         vals[i] = DATA_W'($urandom());
         idxs[i] = 2'($urandom());
         if (pat == 2) begin
            vals[i] = 16'hFFFB;
            idxs[i] = 2'd3;
         end
      end
      if (pat == 1) begin
         for (int i = 0; i < MAP_W; i++) begin
            vals[i] = DATA_W'(10 * (i + 1));
            idxs[i] = 2'(i);
         end
      end

      // Reference model: each output pixel (r,c) of channel ch comes from
      // pooled pixel (r/2, c/2); its window position is (r%2)*2 + c%2.
      exp_q.delete();
      for (int ch = 0; ch < CH; ch++) begin
         for (int r = 0; r < 2 * MAP_H; r++) begin
            for (int c = 0; c < 2 * MAP_W; c++) begin
               exp_t e;
               int   pi;
               int   pos;
               pi   = ch * MAP_W * MAP_H + (r / 2) * MAP_W + (c / 2);
               pos  = (r % 2) * 2 + (c % 2);
               e.v  = (md || (pos == int'(idxs[pi]))) ? vals[pi] : '0;
               e.ch = ch;
               e.fe = (r == 2 * MAP_H - 1) && (c == 2 * MAP_W - 1);
               exp_q.push_back(e);
            end
         end
      end

      ready_pct       = rdy;
      job_outs        = 0;
      in_acc          = 0;
      first_valid_cyc = -1;
      row0_cyc        = -1;

      @(negedge clk);
      start = 1'b1;
      mode  = md;
      @(negedge clk);
      start = 1'b0;
      mode  = ~md;   // must not affect the latched mode
      chk("busy_after_start", 32'(busy), 32'd1);

      fork
         begin : drv
            int t;
            for (int i = 0; i < TOTAL_IN && !abort; i++) begin
               while (($urandom_range(99) >= in_pct) && !abort) @(negedge clk);
               bus.in_valid = 1'b1;
               bus.in_value = vals[i];
               bus.in_index = idxs[i];
               t = 0;
               while (!bus.in_ready && !abort && t < TMO) begin
                  @(negedge clk);
                  t++;
               end
               if (abort) break;
               if (t >= TMO) begin
                  checks++;
                  errors++;
                  $display("FAIL input_timeout: got no in_ready for pixel %0d, expected acceptance", i);
                  break;
               end
               @(negedge clk);
               bus.in_valid = 1'b0;
               in_acc++;
               if (i == MAP_W - 1) row0_cyc = cyc;
               if (flip && i == TOTAL_IN / 2) begin
                  start = 1'b1;
                  mode  = ~md;
                  @(negedge clk);
                  start = 1'b0;
               end
            end
            bus.in_valid = 1'b0;
         end
         begin : wait_end
            int t;
            int pulses;
            int gaps;
            t = 0;
            pulses = 0;
            gaps = 0;
            if (abort_at == 0) begin
               while (pulses == 0 && t < TMO) begin
                  @(negedge clk);
                  t++;
                  if (done) begin
                     pulses = 1;
                     chk("outs_at_done", 32'(job_outs), 32'(TOTAL_OUT));
                     chk("done_latency", 32'(cyc - last_hs_cyc), 32'd1);
                  end else if (!busy) begin
                     gaps++;
                  end
               end
               if (pulses == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL done_timeout: got no done after %0d cycles, expected done", TMO);
               end
               repeat (4) begin
                  @(negedge clk);
                  if (done) pulses++;
               end
               chk("done_pulses", 32'(pulses), 32'd1);
               chk("busy_gaps", 32'(gaps), 32'd0);
               chk("idle_after_done", 32'(busy), 32'd0);
               chk("queue_drained", 32'(exp_q.size()), 32'd0);
               chk("first_out_latency", 32'(first_valid_cyc - row0_cyc), 32'd2);
            end else begin
               while (job_outs < abort_at && t < TMO) begin
                  @(negedge clk);
                  t++;
               end
               chk("outs_before_reset", 32'(job_outs >= abort_at), 32'd1);
               reset_n = 1'b0;
               abort   = 1'b1;
               mon_en  = 1'b0;
               #1;
               chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
               chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
               chk("rst_out_value", 32'(bus.out_value), 32'd0);
               chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
               chk("rst_out_frame_end", 32'(bus.out_frame_end), 32'd0);
               chk("rst_busy", 32'(busy), 32'd0);
               chk("rst_done", 32'(done), 32'd0);
               exp_q.delete();
            end
         end
         begin : stall
            int t;
            t = 0;
            if (stall_at > 0) begin
               while (job_outs < stall_at && t < TMO) begin
                  @(negedge clk);
                  t++;
               end
               force_stall = 1'b1;
               repeat (21) @(negedge clk);
               chk("in_ready_both_full", 32'(bus.in_ready), 32'd0);
               chk("inputs_buffered", 32'(in_acc), 32'(2 * MAP_W));
               force_stall = 1'b0;
            end
         end
      join
      bus.in_valid = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_value = '0;
      bus.in_index = '0;
      reset_n      = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_out_value", 32'(bus.out_value), 32'd0);
      chk("reset_out_ch", 32'(bus.out_ch), 32'd0);
      chk("reset_out_frame_end", 32'(bus.out_frame_end), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(negedge clk);

      run_job(1'b0, 1, 100, 100, 1'b0, 0, 0);    // argmax placement, fixed first row
      run_job(1'b1, 2, 100, 100, 1'b0, 0, 0);    // replicate, negative value
      run_job(1'b0, 0, 100, 100, 1'b0, 10, 0);   // long downstream stall mid-row
      for (int j = 0; j < 3; j++)
         run_job(1'($urandom()), 0, 50, 50, 1'b0, 0, 0);
      run_job(1'b1, 0, 50, 70, 1'b1, 0, 0);      // start pulsed while running
      run_job(1'b0, 0, 100, 100, 1'b0, 0, 5);    // reset after 5 outputs
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      abort   = 1'b0;
      mon_en  = 1'b1;
      @(negedge clk);
      run_job(1'b0, 0, 100, 100, 1'b0, 0, 0);    // clean job after abort

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
